// File: rtl/frame_gate_pkg.sv
// Shared types and constants for the frame gate, capture and SDRAM paths.
package frame_gate_pkg;

  // Frame gate FSM encodings
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SKIP  = 3'd1;
  localparam logic [2:0] ST_ALIGN = 3'd2;
  localparam logic [2:0] ST_PASS  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  // RGB565 pixel as produced by the capture stage
  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } pixel_t;

  // Expected pixels per frame from the line geometry
  function automatic int unsigned frame_pixels(input int unsigned h_pix,
                                               input int unsigned v_lines);
    return h_pix * v_lines;
  endfunction

endpackage

// File: rtl/frame_gate.sv
// frame_gate: forwards only whole, aligned frames to the SDRAM write port.
// Drops SKIP_FRAMES frames after enable, truncates long frames, flags short
// ones and counts good frames. Defining FRAME_GATE_STAT_EN adds saturating
// short/long counters and a line_err pulse for eop-terminated frames whose
// length is not a whole number of lines.
module frame_gate
  import frame_gate_pkg::*;
#(
  parameter int unsigned H_PIX       = 1280,
  parameter int unsigned V_LINES     = 720,
  parameter int unsigned SKIP_FRAMES = 10,
  parameter int unsigned CNT_W       = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] din,
  input  logic        din_vld,
  input  logic        din_sop,
  input  logic        din_eop,
  output logic [15:0] dout,
  output logic        dout_vld,
  output logic        dout_sop,
  output logic        dout_eop,
  output logic        err_short,
  output logic        err_long,
`ifdef FRAME_GATE_STAT_EN
  output logic [15:0] short_cnt,
  output logic [15:0] long_cnt,
  output logic        line_err,
`endif
  output logic [15:0] frame_cnt
);

  localparam int unsigned FRAME_PIXELS = frame_pixels(H_PIX, V_LINES);
  localparam int unsigned SKIP_W       = (SKIP_FRAMES < 2) ? 1 : $clog2(SKIP_FRAMES + 1);
  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(FRAME_PIXELS - 1);
  localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'(SKIP_FRAMES);

  logic [2:0]        state_q, state_d;
  logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;
  logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
  pixel_t            dout_q, dout_d;
  logic              dout_vld_q, dout_vld_d;
  logic              dout_sop_q, dout_sop_d;
  logic              dout_eop_q, dout_eop_d;
  logic              err_short_q, err_short_d;
  logic              err_long_q, err_long_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  logic              start_c;
  logic              fwd_c;
  logic              new_frame_c;
  logic [CNT_W-1:0]  idx_c;

`ifdef FRAME_GATE_STAT_EN
  logic [15:0]       short_cnt_q, short_cnt_d;
  logic [15:0]       long_cnt_q, long_cnt_d;
  logic              line_err_q, line_err_d;
  logic              eop_term_c;
  logic [CNT_W-1:0]  eop_len_c;
`endif

  // Next-state, frame bookkeeping and output computation
  always_comb begin
    state_d     = state_q;
    skip_cnt_d  = skip_cnt_q;
    pix_cnt_d   = pix_cnt_q;
    dout_d      = dout_q;
    dout_vld_d  = 1'b0;
    dout_sop_d  = 1'b0;
    dout_eop_d  = 1'b0;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
    frame_cnt_d = frame_cnt_q;
    fwd_c       = 1'b0;
    new_frame_c = 1'b0;
    idx_c       = '0;
    start_c     = din_vld & din_sop;
`ifdef FRAME_GATE_STAT_EN
    eop_term_c  = 1'b0;
    eop_len_c   = '0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          skip_cnt_d = '0;
          state_d    = (SKIP_FRAMES == 0) ? ST_ALIGN : ST_SKIP;
        end
      end
      ST_SKIP: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (start_c) begin
          skip_cnt_d = skip_cnt_q + SKIP_W'(1);
          if (skip_cnt_d == SKIP_LAST) state_d = ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (start_c) begin
          fwd_c       = 1'b1;
          new_frame_c = 1'b1;
        end
      end
      ST_PASS: begin
        if (din_vld) begin
          if (din_sop) begin
            // Previous frame lost its eop
            err_short_d = 1'b1;
            if (en) begin
              fwd_c       = 1'b1;
              new_frame_c = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            fwd_c = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (start_c) begin
          fwd_c       = 1'b1;
          new_frame_c = 1'b1;
        end else if (din_vld && din_eop) begin
          state_d = ST_ALIGN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Shared handling of a forwarded beat, including the frame end rules
    if (fwd_c) begin
      idx_c      = new_frame_c ? '0 : pix_cnt_q;
      pix_cnt_d  = idx_c + CNT_W'(1);
      dout_d     = pixel_t'(din);
      dout_vld_d = 1'b1;
      dout_sop_d = new_frame_c;
      state_d    = ST_PASS;
      if (din_eop) begin
        dout_eop_d = 1'b1;
        if (idx_c == LAST_IDX) frame_cnt_d = frame_cnt_q + 16'd1;
        else                   err_short_d = 1'b1;
        state_d = en ? ST_ALIGN : ST_IDLE;
`ifdef FRAME_GATE_STAT_EN
        eop_term_c = 1'b1;
        eop_len_c  = pix_cnt_d;
`endif
      end else if (idx_c == LAST_IDX) begin
        dout_eop_d = 1'b1;
        err_long_d = 1'b1;
        state_d    = en ? ST_DRAIN : ST_IDLE;
      end
    end
  end

`ifdef FRAME_GATE_STAT_EN
  // Saturating error counters and line-multiple check
  always_comb begin
    short_cnt_d = short_cnt_q;
    long_cnt_d  = long_cnt_q;
    line_err_d  = 1'b0;
    if (err_short_d && (short_cnt_q != 16'hFFFF)) short_cnt_d = short_cnt_q + 16'd1;
    if (err_long_d && (long_cnt_q != 16'hFFFF))   long_cnt_d  = long_cnt_q + 16'd1;
    if (eop_term_c && ((eop_len_c % CNT_W'(H_PIX)) != '0)) line_err_d = 1'b1;
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      short_cnt_q <= '0;
      long_cnt_q  <= '0;
      line_err_q  <= 1'b0;
    end else begin
      short_cnt_q <= short_cnt_d;
      long_cnt_q  <= long_cnt_d;
      line_err_q  <= line_err_d;
    end
  end

  assign short_cnt = short_cnt_q;
  assign long_cnt  = long_cnt_q;
  assign line_err  = line_err_q;
`endif

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      skip_cnt_q  <= '0;
      pix_cnt_q   <= '0;
      dout_q      <= '0;
      dout_vld_q  <= 1'b0;
      dout_sop_q  <= 1'b0;
      dout_eop_q  <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      skip_cnt_q  <= skip_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      dout_q      <= dout_d;
      dout_vld_q  <= dout_vld_d;
      dout_sop_q  <= dout_sop_d;
      dout_eop_q  <= dout_eop_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign dout      = dout_q;
  assign dout_vld  = dout_vld_q;
  assign dout_sop  = dout_sop_q;
  assign dout_eop  = dout_eop_q;
  assign err_short = err_short_q;
  assign err_long  = err_long_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_frame_gate.sv
// Directed bench for frame_gate with 8x4 frames and two skipped frames.
module tb_frame_gate;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] din;
  logic        din_vld;
  logic        din_sop;
  logic        din_eop;
  logic [15:0] dout;
  logic        dout_vld;
  logic        dout_sop;
  logic        dout_eop;
  logic        err_short;
  logic        err_long;
  logic [15:0] frame_cnt;
`ifdef FRAME_GATE_STAT_EN
  logic [15:0] short_cnt;
  logic [15:0] long_cnt;
  logic        line_err;
`endif

  int          n_tests;
  int          n_fail;
  logic [15:0] exp_dout;

  frame_gate #(
    .H_PIX      (8),
    .V_LINES    (4),
    .SKIP_FRAMES(2),
    .CNT_W      (20)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .din      (din),
    .din_vld  (din_vld),
    .din_sop  (din_sop),
    .din_eop  (din_eop),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_sop (dout_sop),
    .dout_eop (dout_eop),
    .err_short(err_short),
    .err_long (err_long),
`ifdef FRAME_GATE_STAT_EN
    .short_cnt(short_cnt),
    .long_cnt (long_cnt),
    .line_err (line_err),
`endif
    .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive one input cycle, then check the registered result one cycle later
  task automatic beat(input bit v, input bit s, input bit e, input logic [15:0] d,
                      input bit ev, input bit es, input bit ee,
                      input bit eshort, input bit elong);
    @(negedge clk);
    din_vld = v;
    din_sop = s;
    din_eop = e;
    din     = d;
    @(posedge clk);
    #1;
    if (ev) exp_dout = d;
    chk("dout_vld", 16'(dout_vld), 16'(ev));
    chk("dout_sop", 16'(dout_sop), 16'(es));
    chk("dout_eop", 16'(dout_eop), 16'(ee));
    chk("err_short", 16'(err_short), 16'(eshort));
    chk("err_long", 16'(err_long), 16'(elong));
    chk("dout", dout, exp_dout);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 1'b0, 16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One input frame: n beats, sop on beat 0, eop on beat eop_at (-1: none)
  task automatic frame(input int n, input int eop_at, input int fwd_n, input bit eop_out,
                       input int short_at, input int long_at, input int en_off_at,
                       input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      bit ev;
      if (i == en_off_at) en = 1'b0;
      ev = (i < fwd_n);
      beat(1'b1, i == 0, i == eop_at, 16'(base + 16'(i)),
           ev, ev && (i == 0), ev && eop_out && (i == fwd_n - 1),
           i == short_at, i == long_at);
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    exp_dout = 16'h0000;
    rst_n    = 1'b0;
    en       = 1'b0;
    din      = 16'h0000;
    din_vld  = 1'b0;
    din_sop  = 1'b0;
    din_eop  = 1'b0;

    // Reset state
    #23;
    chk("rst_dout_vld", 16'(dout_vld), 16'h0);
    chk("rst_dout", dout, 16'h0);
    chk("rst_frame_cnt", frame_cnt, 16'h0);
    chk("rst_err", 16'({err_short, err_long, dout_sop, dout_eop}), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Enable: first two frames dropped, next two forwarded
    en = 1'b1;
    idle(2);
    frame(32, 31, 0, 1'b0, -1, -1, -1, 16'h1000);
    idle(1);
    frame(32, 31, 0, 1'b0, -1, -1, -1, 16'h1100);
    idle(2);
    frame(32, 31, 32, 1'b1, -1, -1, -1, 16'h1200);
    chk("fc_after_f3", frame_cnt, 16'd1);
    idle(1);
    frame(32, 31, 32, 1'b1, -1, -1, -1, 16'h1300);
    chk("fc_after_f4", frame_cnt, 16'd2);
    idle(2);

    // Short frame: eop on pixel 19
    frame(20, 19, 20, 1'b1, 19, -1, -1, 16'h2000);
    chk("fc_after_short", frame_cnt, 16'd2);
    idle(2);

    // Long frame: truncated at 32, remainder drained
    frame(40, 39, 32, 1'b1, -1, 31, -1, 16'h3000);
    chk("fc_after_long", frame_cnt, 16'd2);
    idle(1);
    frame(32, 31, 32, 1'b1, -1, -1, -1, 16'h3100);
    chk("fc_after_recover", frame_cnt, 16'd3);
    idle(2);

    // Missing eop: new sop after 15 pixels restarts the frame
    frame(15, -1, 15, 1'b0, -1, -1, -1, 16'h4000);
    frame(32, 31, 32, 1'b1, 0, -1, -1, 16'h4100);
    chk("fc_after_missing_eop", frame_cnt, 16'd4);
    idle(2);

    // Disable mid-frame: the frame still completes, then nothing passes
    frame(32, 31, 32, 1'b1, -1, -1, 10, 16'h5000);
    chk("fc_after_disable", frame_cnt, 16'd5);
    idle(2);
    frame(32, 31, 0, 1'b0, -1, -1, -1, 16'h5100);
    chk("fc_while_disabled", frame_cnt, 16'd5);
    idle(2);

    // Re-enable, skip two, forward part of a frame, then reset mid-frame
    en = 1'b1;
    idle(2);
    frame(32, 31, 0, 1'b0, -1, -1, -1, 16'h6000);
    frame(32, 31, 0, 1'b0, -1, -1, -1, 16'h6100);
    frame(5, -1, 5, 1'b0, -1, -1, -1, 16'h6200);
    chk("pre_rst_vld", 16'(dout_vld), 16'h1);
    #2;
    rst_n   = 1'b0;
    din_vld = 1'b0;
    din_sop = 1'b0;
    #1;
    chk("async_rst_vld", 16'(dout_vld), 16'h0);
    chk("async_rst_dout", dout, 16'h0);
    chk("async_rst_fc", frame_cnt, 16'h0);
    chk("async_rst_flags", 16'({dout_sop, dout_eop, err_short, err_long}), 16'h0);
    exp_dout = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // After reset two frames are skipped again
    frame(32, 31, 0, 1'b0, -1, -1, -1, 16'h7000);
    frame(32, 31, 0, 1'b0, -1, -1, -1, 16'h7100);
    frame(32, 31, 32, 1'b1, -1, -1, -1, 16'h7200);
    chk("fc_after_reset_resume", frame_cnt, 16'd1);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
